vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Pixel timing source for the VGA path: raster counters plus sync/blank flags.
//   Drives x, y and active into the overlay generators (emblem, etc.).
//   Drives hsync/vsync to the output pins, aligned to the same pixel.
//   Default timing is 640x480@60 (800x525 total) on a ~25.175 MHz pixel clock.
// PARAMETERS
//   H_ACTIVE 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48
//   V_ACTIVE 480 visible lines/frame;  V_FP 10;  V_SYNC 2;   V_BP 33
//   SYNC_POL 1'b0  asserted level of hsync/vsync (0 = active-low)
//   FRAME_CNT_W 8  width of frame_cnt (only with VGA_FRAME_COUNT_EN)
// PORTS
//   clk          in   1   pixel clock, single clock domain
//   rst_n        in   1   asynchronous, active-low reset
//   pix_ce       in   1   pixel-advance enable; counters step only when 1
//   x            out  10  horizontal count 0..H_TOTAL-1 (799)
//   y            out  10  vertical count 0..V_TOTAL-1 (524)
//   active       out  1   1 iff x<H_ACTIVE && y<V_ACTIVE
//   hsync        out  1   SYNC_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC
//   vsync        out  1   SYNC_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC
//   line_start   out  1   1 iff x==0
//   frame_start  out  1   1 iff x==0 && y==0
//   frame_cnt    out  FRAME_CNT_W  frames completed (present only with VGA_FRAME_COUNT_EN)
// BEHAVIOUR
//   - H_TOTAL = sum of H_* parameters; V_TOTAL = sum of V_* parameters.
//   - Parameter widths must fit in 10 bits; checked at elaboration.
//   - Every output is a flop or a decode of flops that all update on the same edge.
//     Zero skew between x/y and the flags.
//   - Reset (async assert, sync release):
//     x=H_TOTAL-1, y=V_TOTAL-1, active=0, hsync=vsync=~SYNC_POL,
//     line_start=frame_start=0, frame_cnt=0.
//   - First pix_ce edge after reset yields (0,0), active=1, frame_start=1.
//   - pix_ce=0: all state and outputs hold. Flag pulses last one pixel period,
//     not one clk cycle.
//   - pix_ce=1: x increments.
//     At x==H_TOTAL-1, x wraps to 0 and y increments.
//     At x==H_TOTAL-1 && y==V_TOTAL-1, x and y both wrap to 0.
//   - Flags are decoded from next-state counter values and registered, so they
//     match the registered x/y.
//   - No combinational input-to-output path.
//   - Reset asserted mid-frame: outputs immediately take reset values.
//     The frame restarts cleanly at (0,0) and no partial sync pulse is extended.
// CONFIGURATION
//   VGA_FRAME_COUNT_EN defined:
//     - frame_cnt port exists.
//     - It increments, modulo 2^FRAME_CNT_W, on the same edge where
//       frame_start rises (x,y -> 0,0).
//     - Consumers use it for animation.
//   Not defined: port and register absent; all other behaviour identical.
// STRUCTURE
//   - Package vga_timing_pkg holds:
//       - default timing constants H_/V_*;
//       - derived H_TOTAL, V_TOTAL, HS_START/END and VS_START/END;
//       - the 6-bit colour constants shared with the overlay generators.
//   - Sub-module vga_axis_counter:
//       - params TOTAL, ACT, SYNC_S, SYNC_E;
//       - inputs step, outputs cnt, wrap, act, sync;
//       - instantiated twice: horizontal with step=pix_ce, vertical with
//         step=pix_ce & h_wrap.
// TESTING
//   1 Reset, then pix_ce=1 constantly:
//     -> during reset x=799, y=524, active=0, hsync=vsync=1;
//        first edge -> x=0, y=0, active=1, frame_start=1.
//   2 One full line:
//     -> hsync=0 for exactly 96 ticks, x=656..751;
//        active=1 for x=0..639; line period 800 ticks.
//   3 Full frame:
//     -> vsync=0 exactly on y=490..491 (1600 ticks);
//        active count = 307200; frame period 420000 ticks;
//        frame_start once per frame.
//   4 pix_ce toggling 1-of-4:
//     -> outputs hold for 3 clk;
//        frame period = 1680000 clk;
//        frame_start high 4 consecutive clk.
//   5 rst_n asserted at (x=700, y=491) during sync:
//     -> hsync, vsync and active return to reset values the same cycle;
//        after release, restart at (0,0).
//   6 VGA_FRAME_COUNT_EN, FRAME_CNT_W=2, run 5 frames:
//     -> frame_cnt 0,1,2,3,0, each change coincident with frame_start rising.
//        Build without the macro and confirm the port is absent.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults, derived totals and sync
// windows) plus the 6-bit colour codes used by the overlay generators.
package vga_timing_pkg;

    localparam int unsigned CNT_W    = 10;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // RRGGBB, two bits per channel
    localparam logic [5:0] COL_BLACK  = 6'b00_00_00;
    localparam logic [5:0] COL_WHITE  = 6'b11_11_11;
    localparam logic [5:0] COL_RED    = 6'b11_00_00;
    localparam logic [5:0] COL_GREEN  = 6'b00_11_00;
    localparam logic [5:0] COL_BLUE   = 6'b00_00_11;
    localparam logic [5:0] COL_YELLOW = 6'b11_11_00;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with registered active/sync/zero flags
// decoded from the next count, so flags and count change on the same edge.
module vga_axis_counter #(
    parameter int unsigned TOTAL    = 800,
    parameter int unsigned ACT      = 640,
    parameter int unsigned SYNC_S   = 656,
    parameter int unsigned SYNC_E   = 752,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned W        = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         zero,
    output logic         act,
    output logic         sync
);

    localparam logic [W-1:0] LAST_C = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_C  = W'(ACT);
    localparam logic [W-1:0] SS_C   = W'(SYNC_S);
    localparam logic [W-1:0] SE_C   = W'(SYNC_E);

    logic [W-1:0] cnt_q, cnt_d;
    logic         act_q, act_d;
    logic         zero_q, zero_d;
    logic         sync_q, sync_d;

    // Next count: hold, increment, or wrap at the last position
    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            if (cnt_q == LAST_C) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Flag decode from the next count
    always_comb begin
        act_d  = (cnt_d < ACT_C);
        zero_d = (cnt_d == '0);
        if ((cnt_d >= SS_C) && (cnt_d < SE_C)) begin
            sync_d = SYNC_POL;
        end else begin
            sync_d = ~SYNC_POL;
        end
    end

    // Counter and flag registers; reset parks the axis on its last position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= LAST_C;
            act_q  <= 1'b0;
            zero_q <= 1'b0;
            sync_q <= ~SYNC_POL;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            zero_q <= zero_d;
            sync_q <= sync_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = (cnt_q == LAST_C);
    assign zero = zero_q;
    assign act  = act_q;
    assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: x/y counters with aligned active/sync/start flags.
// Optional frame counter output enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE_P = H_ACTIVE,
    parameter int unsigned H_FP_P     = H_FP,
    parameter int unsigned H_SYNC_P   = H_SYNC,
    parameter int unsigned H_BP_P     = H_BP,
    parameter int unsigned V_ACTIVE_P = V_ACTIVE,
    parameter int unsigned V_FP_P     = V_FP,
    parameter int unsigned V_SYNC_P   = V_SYNC,
    parameter int unsigned V_BP_P     = V_BP,
    parameter logic        SYNC_POL   = 1'b0
`ifdef VGA_FRAME_COUNT_EN
    ,
    parameter int unsigned FRAME_CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    localparam int unsigned H_TOT_C = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int unsigned V_TOT_C = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;
    localparam int unsigned HS_S_C  = H_ACTIVE_P + H_FP_P;
    localparam int unsigned VS_S_C  = V_ACTIVE_P + V_FP_P;

    if ((H_TOT_C > (1 << CNT_W)) || (V_TOT_C > (1 << CNT_W))) begin : g_width_check
        $error("vga_timing_gen: raster totals do not fit the 10-bit counters");
    end

    logic h_wrap_s, h_zero_s, h_act_s, h_sync_s;
    logic v_wrap_s, v_zero_s, v_act_s, v_sync_s;
    logic v_step_s;

    assign v_step_s = pix_ce & h_wrap_s;

    vga_axis_counter #(
        .TOTAL    (H_TOT_C),
        .ACT      (H_ACTIVE_P),
        .SYNC_S   (HS_S_C),
        .SYNC_E   (HS_S_C + H_SYNC_P),
        .SYNC_POL (SYNC_POL),
        .W        (CNT_W)
    ) u_h_axis (
        .clk  (clk),
        .rst_n(rst_n),
        .step (pix_ce),
        .cnt  (x),
        .wrap (h_wrap_s),
        .zero (h_zero_s),
        .act  (h_act_s),
        .sync (h_sync_s)
    );

    vga_axis_counter #(
        .TOTAL    (V_TOT_C),
        .ACT      (V_ACTIVE_P),
        .SYNC_S   (VS_S_C),
        .SYNC_E   (VS_S_C + V_SYNC_P),
        .SYNC_POL (SYNC_POL),
        .W        (CNT_W)
    ) u_v_axis (
        .clk  (clk),
        .rst_n(rst_n),
        .step (v_step_s),
        .cnt  (y),
        .wrap (v_wrap_s),
        .zero (v_zero_s),
        .act  (v_act_s),
        .sync (v_sync_s)
    );

    // All flags are ANDs of flops sharing one edge, so no skew against x/y
    assign active      = h_act_s & v_act_s;
    assign hsync       = h_sync_s;
    assign vsync       = v_sync_s;
    assign line_start  = h_zero_s;
    assign frame_start = h_zero_s & v_zero_s;

`ifdef VGA_FRAME_COUNT_EN
    logic                   first_q, first_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // The wrap out of reset starts frame 0 rather than completing one
    always_comb begin
        first_d     = first_q;
        frame_cnt_d = frame_cnt_q;
        if (pix_ce) begin
            first_d = 1'b0;
            if (h_wrap_s && v_wrap_s && !first_q) begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
        end else begin
            first_d     = first_q;
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q     <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            first_q     <= first_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    logic unused_v_wrap_s;
    assign unused_v_wrap_s = v_wrap_s;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for reset/line checks, and a small
// 16x9 raster instance so frame-level and mid-frame reset checks stay short.
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_n_a, ce_a, rst_n_b, ce_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic       act_a, hs_a, vs_a, ls_a, fs_a;
    logic       act_b, hs_b, vs_b, ls_b, fs_b;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] fc_a;
    logic [1:0] fc_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_gen u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n_a),
        .pix_ce     (ce_a),
        .x          (x_a),
        .y          (y_a),
        .active     (act_a),
        .hsync      (hs_a),
        .vsync      (vs_a),
        .line_start (ls_a),
        .frame_start(fs_a)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_cnt  (fc_a)
`endif
    );

    // Small raster: H 8+2+3+3=16 (hsync x=10..12), V 4+1+2+2=9 (vsync y=5..6)
    vga_timing_gen #(
        .H_ACTIVE_P(8), .H_FP_P(2), .H_SYNC_P(3), .H_BP_P(3),
        .V_ACTIVE_P(4), .V_FP_P(1), .V_SYNC_P(2), .V_BP_P(2)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .FRAME_CNT_W(2)
`endif
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n_b),
        .pix_ce     (ce_b),
        .x          (x_b),
        .y          (y_b),
        .active     (act_b),
        .hsync      (hs_b),
        .vsync      (vs_b),
        .line_start (ls_b),
        .frame_start(fs_b)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_cnt  (fc_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low, hs_first, hs_last, act_cnt, ls_cnt, vs_low;
        int ex, ey, mism, fs_cnt, vmin, vmax;
        int bad_hold, steps, n_rise, t_rise0, t_rise1, run, hi_len, budget;
        logic px_ce, prev_fs;
        logic [9:0] px;

        clk = 1'b0;
        rst_n_a = 1'b0; ce_a = 1'b1;
        rst_n_b = 1'b0; ce_b = 1'b1;
        repeat (3) tick();

        // Reset state with pix_ce high
        check_val("rst_x_a", x_a, 799);
        check_val("rst_y_a", y_a, 524);
        check_val("rst_act_a", act_a, 0);
        check_val("rst_hs_a", hs_a, 1);
        check_val("rst_vs_a", vs_a, 1);
        check_val("rst_ls_a", ls_a, 0);
        check_val("rst_fs_a", fs_a, 0);
        check_val("rst_x_b", x_b, 15);
        check_val("rst_y_b", y_b, 8);

        rst_n_a = 1'b1; rst_n_b = 1'b1;
        tick();
        ce_b = 1'b0;
        check_val("first_x_a", x_a, 0);
        check_val("first_y_a", y_a, 0);
        check_val("first_act_a", act_a, 1);
        check_val("first_fs_a", fs_a, 1);
        check_val("first_ls_a", ls_a, 1);
        check_val("first_hs_a", hs_a, 1);

        // One full line on the default raster
        hs_low = 0; hs_first = -1; hs_last = -1; act_cnt = 0; ls_cnt = 0; vs_low = 0; mism = 0;
        for (int k = 0; k < 800; k++) begin
            if (x_a != 10'(k)) mism++;
            if (!hs_a) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(x_a);
                hs_last = int'(x_a);
            end
            if (act_a) act_cnt++;
            if (ls_a) ls_cnt++;
            if (!vs_a) vs_low++;
            tick();
        end
        check_val("line_x_track", mism, 0);
        check_val("line_hs_low", hs_low, 96);
        check_val("line_hs_first", hs_first, 656);
        check_val("line_hs_last", hs_last, 751);
        check_val("line_active", act_cnt, 640);
        check_val("line_ls_cnt", ls_cnt, 1);
        check_val("line_vs_low", vs_low, 0);
        check_val("line_end_x", x_a, 0);
        check_val("line_end_y", y_a, 1);

        // pix_ce low holds counters and the line_start pulse
        ce_a = 1'b0;
        repeat (3) tick();
        check_val("hold_x_a", x_a, 0);
        check_val("hold_y_a", y_a, 1);
        check_val("hold_ls_a", ls_a, 1);
        ce_a = 1'b1;
        tick();
        check_val("step_x_a", x_a, 1);
        check_val("step_ls_a", ls_a, 0);

        // Small raster held at (0,0) while the default instance ran
        check_val("hold_x_b", x_b, 0);
        check_val("hold_fs_b", fs_b, 1);

        // Full frame on the small raster against a reference model
        ce_b = 1'b1;
        ex = 0; ey = 0; mism = 0; hs_low = 0; vs_low = 0; act_cnt = 0; fs_cnt = 0;
        vmin = 99; vmax = -1;
        for (int k = 0; k < 144; k++) begin
            if (x_b != 10'(ex) || y_b != 10'(ey)) mism++;
            if (act_b !== ((ex < 8) && (ey < 4))) mism++;
            if (hs_b !== !((ex >= 10) && (ex < 13))) mism++;
            if (vs_b !== !((ey >= 5) && (ey < 7))) mism++;
            if (ls_b !== (ex == 0)) mism++;
            if (fs_b !== ((ex == 0) && (ey == 0))) mism++;
            if (!hs_b) hs_low++;
            if (!vs_b) begin
                vs_low++;
                if (int'(y_b) < vmin) vmin = int'(y_b);
                if (int'(y_b) > vmax) vmax = int'(y_b);
            end
            if (act_b) act_cnt++;
            if (fs_b) fs_cnt++;
            tick();
            if (ex == 15) begin
                ex = 0;
                ey = (ey == 8) ? 0 : ey + 1;
            end else begin
                ex = ex + 1;
            end
        end
        check_val("frame_model", mism, 0);
        check_val("frame_vs_low", vs_low, 32);
        check_val("frame_vs_ymin", vmin, 5);
        check_val("frame_vs_ymax", vmax, 6);
        check_val("frame_hs_low", hs_low, 27);
        check_val("frame_active", act_cnt, 32);
        check_val("frame_fs_cnt", fs_cnt, 1);
        check_val("frame_wrap_x", x_b, 0);
        check_val("frame_wrap_y", y_b, 0);
        check_val("frame_wrap_fs", fs_b, 1);

        // pix_ce one clock in four: pulses stretch to one pixel period
        bad_hold = 0; steps = 0; n_rise = 0; t_rise0 = 0; t_rise1 = 0;
        run = 0; hi_len = 0; prev_fs = fs_b;
        for (int i = 0; i < 1160; i++) begin
            ce_b = (i % 4 == 3);
            px_ce = ce_b;
            px = x_b;
            tick();
            if (x_b != px) begin
                if (px_ce) steps++;
                else bad_hold++;
            end
            if (fs_b && !prev_fs) begin
                if (n_rise == 0) t_rise0 = i;
                if (n_rise == 1) t_rise1 = i;
                n_rise++;
            end
            if (fs_b) begin
                run++;
            end else begin
                if (prev_fs && n_rise > 0 && hi_len == 0) hi_len = run;
                run = 0;
            end
            prev_fs = fs_b;
        end
        check_val("ce4_hold", bad_hold, 0);
        check_val("ce4_steps", steps, 290);
        check_val("ce4_rises", n_rise, 2);
        check_val("ce4_period", t_rise1 - t_rise0, 576);
        check_val("ce4_fs_len", hi_len, 4);

        // Advance to (11,6): inside both hsync and vsync, then reset mid-cycle
        ce_b = 1'b1;
        budget = 0;
        while (!(x_b == 10'd11 && y_b == 10'd6) && budget < 300) begin
            tick();
            budget++;
        end
        check_val("mid_reach", budget < 300, 1);
        check_val("mid_hs_pre", hs_b, 0);
        check_val("mid_vs_pre", vs_b, 0);
        #2;
        rst_n_b = 1'b0;
        #1;
        check_val("mid_rst_x", x_b, 15);
        check_val("mid_rst_y", y_b, 8);
        check_val("mid_rst_hs", hs_b, 1);
        check_val("mid_rst_vs", vs_b, 1);
        check_val("mid_rst_act", act_b, 0);
        check_val("mid_rst_fs", fs_b, 0);
`ifdef VGA_FRAME_COUNT_EN
        check_val("mid_rst_fc", fc_b, 0);
`endif
        tick();
        rst_n_b = 1'b1;
        tick();
        check_val("restart_x", x_b, 0);
        check_val("restart_y", y_b, 0);
        check_val("restart_act", act_b, 1);
        check_val("restart_fs", fs_b, 1);
        check_val("restart_hs", hs_b, 1);

`ifdef VGA_FRAME_COUNT_EN
        // Frame counter over five frames, 2-bit wide
        begin
            logic [1:0] fc_seen[5];
            logic [1:0] prev_fc;
            int off_edge;
            n_rise = 0; off_edge = 0; prev_fs = 1'b0; prev_fc = 2'd0;
            for (int k = 0; k < 720; k++) begin
                if (fs_b && !prev_fs) begin
                    if (n_rise < 5) fc_seen[n_rise] = fc_b;
                    n_rise++;
                end else if (fc_b != prev_fc) begin
                    off_edge++;
                end
                prev_fs = fs_b;
                prev_fc = fc_b;
                tick();
            end
            check_val("fc_rises", n_rise, 5);
            check_val("fc_off_edge", off_edge, 0);
            check_val("fc_f0", fc_seen[0], 0);
            check_val("fc_f1", fc_seen[1], 1);
            check_val("fc_f2", fc_seen[2], 2);
            check_val("fc_f3", fc_seen[3], 3);
            check_val("fc_f4", fc_seen[4], 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
